serial_subtractor: RTL and testbench

- Multi-cycle, bit-serial two's-complement subtractor: diff = a - b - bin over WIDTH bits.
- Processes one bit per clock, LSB first, with a single registered borrow flop.
- Inverse-direction companion to the ripple-carry adder datapath.
- Valid/ready handshake on both input and output so it drops into the same datapaths as the adder with pipeline backpressure.

---
 rtl/serial_subtractor.sv | 90 +++++++++
 tb/tb_serial_subtractor.sv | 106 ++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b - bin with valid/ready handshakes
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, wd_q, wd_d, diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic br_q, br_d, bout_q, bout_d, ovf_q, ovf_d, d_bit, last;
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        wd_d    = wd_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        d_bit   = a_q[0] ^ b_q[0] ^ br_q;
        last    = cnt_q == CW'(WIDTH - 1);
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                br_d    = bin;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
                wd_d  = {d_bit, wd_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                // on the last bit the shift regs hold the original operand MSBs
                if (last) begin
                    state_d = DONE;
                    diff_d  = wd_d;
                    bout_d  = br_d;
                    ovf_d   = (a_q[0] != b_q[0]) && (d_bit != a_q[0]);
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            wd_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wd_q    <= wd_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors with hand-computed results for serial_subtractor
module tb_serial_subtractor;
    logic clk = 0, rst = 1, in_valid = 0, bin = 0, out_ready = 0;
    logic [7:0] a = 0, b = 0, diff;
    logic in_ready, out_valid, bout, ovf;
    int n_vec = 0, n_bad = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                          input logic [7:0] ed, input logic eb, input logic eo,
                          input int hold, input bit disturb);
        int cyc;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        a = ta; b = tb_; bin = tbin; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (disturb && !out_valid) begin
                a = ~a; b = b + 8'd1; bin = ~bin; in_valid = 1;
                check("in_ready_run", in_ready, 0);
            end
        end while (!out_valid && cyc < 40);
        check("latency", cyc, 8);
        check("diff", diff, ed);
        check("bout", bout, eb);
        check("ovf", ovf, eo);
        for (int i = 0; i < hold; i++) begin
            if (disturb) begin
                in_valid = ~in_valid; a = a ^ 8'h5A; b = b + 8'd3;
            end
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_diff", diff, ed);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = disturb;
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0; in_valid = 0;
        @(negedge clk);
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_diff", diff, ed);
    endtask

    initial begin
        int saw;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk) rst = 0;

        run_op(8'd100, 8'd37, 0, 8'd63, 0, 0, 2, 0);
        run_op(8'd5, 8'd10, 0, 8'd251, 1, 0, 0, 0);
        run_op(8'h80, 8'h01, 0, 8'h7F, 0, 1, 0, 0);
        run_op(8'h7F, 8'hFF, 0, 8'h80, 1, 1, 0, 0);
        run_op(8'd0, 8'd0, 1, 8'hFF, 1, 0, 0, 0);
        run_op(8'd200, 8'd55, 0, 8'd145, 0, 0, 5, 1);

        @(negedge clk);
        a = 8'd50; b = 8'd20; bin = 0; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (4) @(posedge clk);
        #3 rst = 1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_diff", diff, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk) rst = 0;
        saw = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) saw++;
        end
        check("no_stale_valid", saw, 0);
        run_op(8'd9, 8'd3, 0, 8'd6, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
